alu_writeback: RTL

ALU_WRITEBACK -- requirements
Module: alu_writeback

---
 rtl/mips_pkg.sv | 33 +++
 rtl/alu_writeback_if.sv | 28 ++
 rtl/wb_fifo2.sv | 46 ++++
 rtl/alu_writeback.sv | 71 +++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared field widths, funct codes and the legal-funct check used
// by the ALU writeback path.
//   reg_t      - 5-bit register-file address
//   data_t     - 32-bit data word
//   wb_entry_t - one pending register-file write (destination + data)
package mips_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef logic [REG_W-1:0]  reg_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam logic [5:0] F_ADD = 6'd32;
  localparam logic [5:0] F_SUB = 6'd34;
  localparam logic [5:0] F_AND = 6'd36;
  localparam logic [5:0] F_OR  = 6'd37;
  localparam logic [5:0] F_NOR = 6'd39;
  localparam logic [5:0] F_SLT = 6'd42;

  typedef struct packed {
    reg_t  rd;
    data_t data;
  } wb_entry_t;

  function automatic logic funct_legal(input logic [5:0] f);
    case (f)
      F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT: funct_legal = 1'b1;
      default:                                 funct_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// alu_writeback_if: result input channel plus register-file write channel.
//   in_valid/in_ready/in_rd/in_funct/in_result - ALU result handshake
//   RegWrite/WriteReg/WriteData/wr_ready        - register-file write handshake
// modport slave  : the writeback block
// modport master : the environment (ALU side and register file)
interface alu_writeback_if;
  import mips_pkg::*;

  logic       in_valid;
  logic       in_ready;
  reg_t       in_rd;
  logic [5:0] in_funct;
  data_t      in_result;
  logic       RegWrite;
  reg_t       WriteReg;
  data_t      WriteData;
  logic       wr_ready;

  modport slave (
    input  in_valid, in_rd, in_funct, in_result, wr_ready,
    output in_ready, RegWrite, WriteReg, WriteData
  );

  modport master (
    output in_valid, in_rd, in_funct, in_result, wr_ready,
    input  in_ready, RegWrite, WriteReg, WriteData
  );
endinterface

// File: rtl/wb_fifo2.sv
// wb_fifo2: 2-entry in-order FIFO of pending register writes.
//   CLK, RESET  - clock, synchronous active-high reset
//   push/entry  - enqueue (caller guarantees not full)
//   pop         - dequeue head (caller guarantees not empty)
//   count       - occupancy 0..2
//   head        - oldest entry
//   tail        - youngest entry (equals head when count==1)
module wb_fifo2
  import mips_pkg::*;
(
  input  logic      CLK,
  input  logic      RESET,
  input  logic      push,
  input  wb_entry_t entry,
  input  logic      pop,
  output logic [1:0] count,
  output wb_entry_t head,
  output wb_entry_t tail
);

  wb_entry_t mem [2];
  logic      wr_ptr;
  logic      rd_ptr;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage needs no reset: stale words are never visible because the
  // outputs that expose them are qualified by occupancy in the parent.
  always_ff @(posedge CLK) begin
    if (push && !RESET) mem[wr_ptr] <= entry;
  end

  assign head = mem[rd_ptr];
  assign tail = mem[~wr_ptr];

endmodule

// File: rtl/alu_writeback.sv
// alu_writeback: filters ALU results, buffers legal ones in a 2-entry FIFO
// and drains them to the register file; exposes the youngest pending write
// for forwarding and counts retired and illegal results.
//   CLK, RESET     - clock, synchronous active-high reset
//   bus (slave)    - result input and register-file write channels
//   fwd_valid/reg/data - youngest pending write
//   retired_count  - completed writes (wraps at 2^16)
//   illegal_count  - dropped illegal-funct results (saturates at 255)
module alu_writeback
  import mips_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  alu_writeback_if.slave     bus,
  output logic               fwd_valid,
  output reg_t               fwd_reg,
  output data_t              fwd_data,
  output logic [15:0]        retired_count,
  output logic [7:0]         illegal_count
);

  logic [1:0] occ;
  wb_entry_t  head, tail, entry;
  logic       accept, legal, push, pop, zero_retire, illegal;

  // in_ready depends only on registered occupancy; a same-cycle pop never
  // opens a slot for a push when full.
  assign bus.in_ready = (occ != 2'd2);
  assign accept       = bus.in_valid & bus.in_ready;
  assign legal        = funct_legal(bus.in_funct);
  assign push         = accept & legal & (bus.in_rd != '0);
  assign zero_retire  = accept & legal & (bus.in_rd == '0);
  assign illegal      = accept & ~legal;
  assign pop          = bus.RegWrite & bus.wr_ready;

  assign entry.rd   = bus.in_rd;
  assign entry.data = bus.in_result;

  wb_fifo2 u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (push),
    .entry (entry),
    .pop   (pop),
    .count (occ),
    .head  (head),
    .tail  (tail)
  );

  assign bus.RegWrite  = (occ != 2'd0);
  assign bus.WriteReg  = bus.RegWrite ? head.rd   : '0;
  assign bus.WriteData = bus.RegWrite ? head.data : '0;

  // The tail is the youngest entry for both occupancies 1 and 2.
  assign fwd_valid = (occ != 2'd0);
  assign fwd_reg   = fwd_valid ? tail.rd   : '0;
  assign fwd_data  = fwd_valid ? tail.data : '0;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      retired_count <= 16'd0;
      illegal_count <= 8'd0;
    end else begin
      // rd=0 discards retire immediately and may coincide with a pop.
      retired_count <= retired_count + {15'd0, pop} + {15'd0, zero_retire};
      if (illegal && illegal_count != 8'hFF)
        illegal_count <= illegal_count + 8'd1;
    end
  end

endmodule
